// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer: FSM state encodings.
package stream_demux_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ROUTE = 2'd1;
   localparam state_t ST_DROP  = 2'd2;

endpackage

// File: rtl/stream_demux_if.sv
// Stream bundle for the demux: one input stream and CHANNELS output streams.
interface stream_demux_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          in_data;
   logic                      in_last;
   logic [SEL_W-1:0]          in_sel;
   logic [CHANNELS-1:0]       out_valid;
   logic [CHANNELS-1:0]       out_ready;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic [CHANNELS-1:0]       out_last;

   modport slave (
      input  in_valid, in_data, in_last, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register for a demux channel; data is kept after the entry drains.
module stream_demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             last_in,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last,
   output logic             free
);

   assign free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= data_in;
         last  <= last_in;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS packet demux; the select is locked on the first beat of a packet.
//  state | meaning
//  IDLE  | waiting for a first beat; target comes straight from in_sel
//  ROUTE | packet in progress, beats go to the latched channel
//  DROP  | packet had an invalid select, beats are swallowed until in_last
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   stream_demux_if.slave    bus,
   output logic             busy,
   output logic [CNT_W-1:0] drop_count
);

   state_t                    state;
   logic [SEL_W-1:0]          sel_q;
   logic [SEL_W-1:0]          target;
   logic                      sel_ok;
   logic                      tgt_free;
   logic                      route_beat;
   logic                      accept;
   logic                      in_ready;
   logic [CHANNELS-1:0]       slot_free;
   logic [CHANNELS-1:0]       load;
   logic [CHANNELS-1:0]       valid_v;
   logic [CHANNELS-1:0]       last_v;
   logic [CHANNELS*WIDTH-1:0] data_v;

   // sel_ok is only meaningful in IDLE; the latched select is always in range.
   always_comb begin
      target   = (state == ST_IDLE) ? bus.in_sel : sel_q;
      sel_ok   = 1'b0;
      tgt_free = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (target == SEL_W'(k)) begin
            sel_ok   = 1'b1;
            tgt_free = slot_free[k];
         end
      end
   end

   assign route_beat = (state == ST_ROUTE) || ((state == ST_IDLE) && sel_ok);
   assign in_ready   = route_beat ? tgt_free : 1'b1;
   assign accept     = bus.in_valid && in_ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         load[k] = accept && route_beat && (target == SEL_W'(k));
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
      stream_demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load[k]),
         .data_in (bus.in_data),
         .last_in (bus.in_last),
         .ready   (bus.out_ready[k]),
         .valid   (valid_v[k]),
         .data    (data_v[k*WIDTH +: WIDTH]),
         .last    (last_v[k]),
         .free    (slot_free[k])
      );
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_v;
   assign bus.out_data  = data_v;
   assign bus.out_last  = last_v;
   assign busy          = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sel_q      <= '0;
         drop_count <= '0;
      end else if (accept) begin
         case (state)
            ST_IDLE: begin
               if (sel_ok) begin
                  sel_q <= bus.in_sel;
                  if (!bus.in_last) state <= ST_ROUTE;
               end else begin
                  if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
                  if (!bus.in_last) state <= ST_DROP;
               end
            end
            ST_ROUTE, ST_DROP: begin
               if (bus.in_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance driven from a vector table and
// a 3-channel instance used for invalid-select drop and counter saturation.
module tb_stream_demux;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy4, busy3;
   logic [7:0] drop4, drop3;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   stream_demux_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) i4 ();
   stream_demux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) i3 ();

   stream_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (i4),
      .busy       (busy4),
      .drop_count (drop4)
   );

   stream_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (i3),
      .busy       (busy3),
      .drop_count (drop3)
   );

   typedef struct {
      logic       v;
      logic [1:0] sel;
      logic [7:0] d;
      logic       l;
      logic [3:0] ordy;
      logic       e_rdy;
      logic [3:0] e_ov;
      logic [1:0] e_ch;
      logic [7:0] e_d;
      logic       e_l;
      logic       e_busy;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(logic v, logic [1:0] sel, logic [7:0] d, logic l,
                               logic [3:0] ordy, logic e_rdy, logic [3:0] e_ov,
                               logic [1:0] e_ch, logic [7:0] e_d, logic e_l, logic e_busy);
      vec_t r;
      r.v = v; r.sel = sel; r.d = d; r.l = l; r.ordy = ordy;
      r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_ch = e_ch; r.e_d = e_d; r.e_l = e_l;
      r.e_busy = e_busy;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic l, input logic [3:0] ordy);
      i4.in_valid  = v;
      i4.in_sel    = sel;
      i4.in_data   = d;
      i4.in_last   = l;
      i4.out_ready = ordy;
   endtask

   initial begin
      //          v  sel  data   l  ordy     rdy ov       ch  data   l  busy
      vt[0]  = mk(1, 2, 8'h11, 0, 4'b1111, 1, 4'b0100, 2, 8'h11, 0, 1);
      vt[1]  = mk(1, 2, 8'h22, 0, 4'b1111, 1, 4'b0100, 2, 8'h22, 0, 1);
      vt[2]  = mk(1, 2, 8'h33, 1, 4'b1111, 1, 4'b0100, 2, 8'h33, 1, 0);
      vt[3]  = mk(0, 2, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
      vt[4]  = mk(1, 1, 8'h44, 0, 4'b1101, 1, 4'b0010, 1, 8'h44, 0, 1);
      vt[5]  = mk(1, 1, 8'h55, 0, 4'b1101, 0, 4'b0010, 1, 8'h44, 0, 1);
      vt[6]  = mk(1, 3, 8'h55, 0, 4'b1111, 1, 4'b0010, 1, 8'h55, 0, 1);
      vt[7]  = mk(1, 3, 8'h66, 1, 4'b1111, 1, 4'b0010, 1, 8'h66, 1, 0);
      vt[8]  = mk(1, 3, 8'h77, 1, 4'b1111, 1, 4'b1000, 3, 8'h77, 1, 0);
      vt[9]  = mk(1, 0, 8'h80, 1, 4'b1111, 1, 4'b0001, 0, 8'h80, 1, 0);
      vt[10] = mk(1, 1, 8'h81, 1, 4'b1111, 1, 4'b0010, 1, 8'h81, 1, 0);
      vt[11] = mk(1, 0, 8'h82, 1, 4'b1111, 1, 4'b0001, 0, 8'h82, 1, 0);
      vt[12] = mk(1, 1, 8'h83, 1, 4'b1111, 1, 4'b0010, 1, 8'h83, 1, 0);
      vt[13] = mk(0, 1, 8'h00, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);

      rst_n = 1'b0;
      drive4(0, 0, 8'h00, 0, 4'b0000);
      i3.in_valid = 0; i3.in_sel = 0; i3.in_data = 0; i3.in_last = 0; i3.out_ready = 0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("reset out_valid", i4.out_valid, 0);
      chk("reset out_data", i4.out_data, 0);
      chk("reset out_last", i4.out_last, 0);
      chk("reset busy", busy4, 0);
      chk("reset drop_count", drop4, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive4(vt[i].v, vt[i].sel, vt[i].d, vt[i].l, vt[i].ordy);
         @(negedge clk);
         chk($sformatf("v%0d in_ready", i), i4.in_ready, vt[i].e_rdy);
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), i4.out_valid, vt[i].e_ov);
         chk($sformatf("v%0d busy", i), busy4, vt[i].e_busy);
         chk($sformatf("v%0d drop_count", i), drop4, 0);
         if (vt[i].e_ov != 4'b0000) begin
            chk($sformatf("v%0d out_data", i), i4.out_data[vt[i].e_ch*8 +: 8], vt[i].e_d);
            chk($sformatf("v%0d out_last", i), i4.out_last[vt[i].e_ch], vt[i].e_l);
         end
      end

      // Invalid select on the 3-channel instance: whole packets swallowed, counter saturates.
      i3.out_ready = 3'b111;
      for (int p = 0; p < 300; p++) begin
         i3.in_valid = 1; i3.in_sel = 2'd3; i3.in_data = 8'hC0; i3.in_last = 0;
         @(negedge clk);
         if (p == 0) chk("drop beat1 in_ready", i3.in_ready, 1);
         @(posedge clk); #1;
         if (p == 0) begin
            chk("drop beat1 count", drop3, 1);
            chk("drop beat1 busy", busy3, 1);
            chk("drop beat1 out_valid", i3.out_valid, 0);
         end
         i3.in_sel = 2'd0; i3.in_data = 8'hC1; i3.in_last = 1;
         @(negedge clk);
         if (p == 0) chk("drop beat2 in_ready", i3.in_ready, 1);
         @(posedge clk); #1;
         if (p == 0) begin
            chk("drop beat2 count", drop3, 1);
            chk("drop beat2 busy", busy3, 0);
            chk("drop beat2 out_valid", i3.out_valid, 0);
         end
         if (p == 254) chk("drop count at 255 packets", drop3, 255);
      end
      chk("drop count saturated", drop3, 255);

      i3.in_sel = 2'd3; i3.in_data = 8'hC2; i3.in_last = 1;
      @(posedge clk); #1;
      chk("single drop busy", busy3, 0);
      chk("single drop out_valid", i3.out_valid, 0);
      i3.in_sel = 2'd2; i3.in_data = 8'h3C; i3.in_last = 1;
      @(posedge clk); #1;
      chk("ch3dut route out_valid", i3.out_valid, 3'b100);
      chk("ch3dut route data", i3.out_data[23:16], 8'h3C);
      i3.in_valid = 0;

      // Asynchronous reset in the middle of a 4-beat packet.
      drive4(1, 2, 8'hA0, 0, 4'b1111);
      @(posedge clk); #1;
      chk("pre-reset out_valid", i4.out_valid, 4'b0100);
      chk("pre-reset busy", busy4, 1);
      drive4(1, 2, 8'hA1, 0, 4'b1111);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", i4.out_valid, 0);
      chk("async reset out_data", i4.out_data, 0);
      chk("async reset busy", busy4, 0);
      chk("async reset drop3", drop3, 0);
      drive4(0, 0, 8'h00, 0, 4'b1111);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-reset busy", busy4, 0);
      drive4(1, 0, 8'hB0, 0, 4'b1111);
      @(posedge clk); #1;
      chk("post-reset beat1 out_valid", i4.out_valid, 4'b0001);
      chk("post-reset beat1 data", i4.out_data[7:0], 8'hB0);
      chk("post-reset beat1 busy", busy4, 1);
      drive4(1, 2, 8'hB1, 1, 4'b1111);
      @(posedge clk); #1;
      chk("post-reset beat2 out_valid", i4.out_valid, 4'b0001);
      chk("post-reset beat2 data", i4.out_data[7:0], 8'hB1);
      chk("post-reset beat2 last", i4.out_last[0], 1);
      chk("post-reset beat2 busy", busy4, 0);
      drive4(0, 0, 8'h00, 0, 4'b1111);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
